// File: rtl/bus_cycle_ctrl.sv
// Z80 bus cycle sequencer: turns an accepted machine-cycle request into T-state
// pin activity (T1/T2/TW/T3/T4), captures read data and arbitrates bus requests.
module bus_cycle_ctrl (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    input  logic [2:0]  req_type,
    output logic        req_ready,
    input  logic [15:0] addr_in,
    input  logic [15:0] rfsh_addr,
    input  logic [7:0]  dout_in,
    output logic [7:0]  din_out,
    output logic        done,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        d_oe,
    input  logic [7:0]  D_in,
    output logic        pin_oe,
    output logic        nM1,
    output logic        nMREQ,
    output logic        nIORQ,
    output logic        nRD,
    output logic        nWR,
    output logic        nRFSH,
    input  logic        nWAIT,
    input  logic        nBUSRQ,
    output logic        nBUSACK
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TW_BITS = 3;

    localparam logic [TW_BITS-1:0] TYP_FETCH = TW_BITS'(0);
    localparam logic [TW_BITS-1:0] TYP_MEMRD = TW_BITS'(1);
    localparam logic [TW_BITS-1:0] TYP_MEMWR = TW_BITS'(2);
    localparam logic [TW_BITS-1:0] TYP_IORD  = TW_BITS'(3);
    localparam logic [TW_BITS-1:0] TYP_IOWR  = TW_BITS'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_BUSACK
    } state_t;

    typedef struct packed {
        logic [TW_BITS-1:0] typ;
        logic [AW-1:0]      addr;
        logic [DW-1:0]      data;
    } cyc_t;

    state_t state_q, state_nx;
    cyc_t   cyc_q, cyc_nx;
    logic   is_final;
    logic   is_fetch_q;
    logic   is_io_q;
    logic   can_accept;

    logic [AW-1:0] a_nx;
    logic [DW-1:0] d_out_nx;
    logic [DW-1:0] din_nx;
    logic          d_oe_nx, pin_oe_nx, nbusack_nx, done_nx;
    logic          nm1_nx, nmreq_nx, niorq_nx, nrd_nx, nwr_nx, nrfsh_nx;
    logic          is_wr_nx;

    assign is_fetch_q = (cyc_q.typ == TYP_FETCH);
    assign is_io_q    = (cyc_q.typ == TYP_IORD) || (cyc_q.typ == TYP_IOWR);
    assign is_final   = (state_q == S_T4) || ((state_q == S_T3) && !is_fetch_q);
    assign can_accept = (state_q == S_IDLE) || is_final;
    assign req_ready  = can_accept && nBUSRQ;

    // Next state and next latched request
    always_comb begin
        state_nx = state_q;
        cyc_nx   = cyc_q;
        if (can_accept) begin
            state_nx = S_IDLE;
            if (!nBUSRQ) begin
                state_nx = S_BUSACK;
            end else if (req_valid && (req_type <= TYP_IOWR)) begin
                state_nx    = S_T1;
                cyc_nx.typ  = req_type;
                cyc_nx.addr = addr_in;
                cyc_nx.data = dout_in;
            end
        end else begin
            unique case (state_q)
                S_T1:     state_nx = S_T2;
                S_T2:     state_nx = (!nWAIT || is_io_q) ? S_TW : S_T3;
                S_TW:     state_nx = (!nWAIT) ? S_TW : S_T3;
                S_T3:     state_nx = S_T4;
                S_BUSACK: state_nx = nBUSRQ ? S_IDLE : S_BUSACK;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Pin values for the state being entered
    always_comb begin
        a_nx       = A;
        d_out_nx   = D_out;
        d_oe_nx    = 1'b0;
        pin_oe_nx  = 1'b1;
        nbusack_nx = 1'b1;
        nm1_nx     = 1'b1;
        nmreq_nx   = 1'b1;
        niorq_nx   = 1'b1;
        nrd_nx     = 1'b1;
        nwr_nx     = 1'b1;
        nrfsh_nx   = 1'b1;
        is_wr_nx   = (cyc_nx.typ == TYP_MEMWR) || (cyc_nx.typ == TYP_IOWR);

        unique case (state_nx)
            S_T1: begin
                a_nx = cyc_nx.addr;
                unique case (cyc_nx.typ)
                    TYP_FETCH: begin nm1_nx = 1'b0; nmreq_nx = 1'b0; nrd_nx = 1'b0; end
                    TYP_MEMRD: begin nmreq_nx = 1'b0; nrd_nx = 1'b0; end
                    TYP_MEMWR: nmreq_nx = 1'b0;
                    default: ;
                endcase
            end
            S_T2, S_TW, S_T3: begin
                if ((state_nx == S_T3) && (cyc_nx.typ == TYP_FETCH)) begin
                    a_nx     = rfsh_addr;
                    nmreq_nx = 1'b0;
                    nrfsh_nx = 1'b0;
                end else begin
                    a_nx = cyc_nx.addr;
                    unique case (cyc_nx.typ)
                        TYP_FETCH: begin nm1_nx = 1'b0; nmreq_nx = 1'b0; nrd_nx = 1'b0; end
                        TYP_MEMRD: begin nmreq_nx = 1'b0; nrd_nx = 1'b0; end
                        TYP_MEMWR: begin nmreq_nx = 1'b0; nwr_nx = 1'b0; end
                        TYP_IORD:  begin niorq_nx = 1'b0; nrd_nx = 1'b0; end
                        TYP_IOWR:  begin niorq_nx = 1'b0; nwr_nx = 1'b0; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                a_nx     = rfsh_addr;
                nmreq_nx = 1'b0;
                nrfsh_nx = 1'b0;
            end
            S_BUSACK: begin
                pin_oe_nx  = 1'b0;
                nbusack_nx = 1'b0;
            end
            default: ;
        endcase

        if (is_wr_nx && ((state_nx == S_T1) || (state_nx == S_T2) ||
                         (state_nx == S_TW) || (state_nx == S_T3))) begin
            d_oe_nx  = 1'b1;
            d_out_nx = cyc_nx.data;
        end
    end

    // Read capture: fetch samples entering T3, other reads sample leaving T3
    always_comb begin
        din_nx  = din_out;
        done_nx = is_final;
        if (is_fetch_q && ((state_q == S_T2) || (state_q == S_TW)) && (state_nx == S_T3)) begin
            din_nx = D_in;
        end
        if ((state_q == S_T3) && ((cyc_q.typ == TYP_MEMRD) || (cyc_q.typ == TYP_IORD))) begin
            din_nx = D_in;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_nx;
            cyc_q   <= cyc_nx;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            A       <= '0;
            D_out   <= '0;
            d_oe    <= 1'b0;
            pin_oe  <= 1'b1;
            nBUSACK <= 1'b1;
            nM1     <= 1'b1;
            nMREQ   <= 1'b1;
            nIORQ   <= 1'b1;
            nRD     <= 1'b1;
            nWR     <= 1'b1;
            nRFSH   <= 1'b1;
            din_out <= '0;
            done    <= 1'b0;
        end else begin
            A       <= a_nx;
            D_out   <= d_out_nx;
            d_oe    <= d_oe_nx;
            pin_oe  <= pin_oe_nx;
            nBUSACK <= nbusack_nx;
            nM1     <= nm1_nx;
            nMREQ   <= nmreq_nx;
            nIORQ   <= niorq_nx;
            nRD     <= nrd_nx;
            nWR     <= nwr_nx;
            nRFSH   <= nrfsh_nx;
            din_out <= din_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Downstream of `address_latch`: turns a requested machine cycle into Z80 pin activity. Latches the 16-bit `address` output of the latch and the write data. Sequences T-states T1/T2/TW/T3/T4, drives the memory/IO strobes, samples `nWAIT` and read data, and arbitrates `nBUSRQ`/`nBUSACK`. All pin outputs are registered on the rising edge of `clk`; there is no half-clock strobe timing.

## Interface
Parameters: none.
- clk  in  1  CPU clock; all state changes on rising edge
- nreset  in  1  asynchronous, active-low reset
- req_valid  in  1  machine-cycle request
- req_type  in  3  0 fetch (M1), 1 mem read, 2 mem write, 3 IO read, 4 IO write, 5-7 reserved
- req_ready  out  1  request accepted on the edge where `req_valid & req_ready`
- addr_in  in  16  cycle address, from `address_latch.address`
- rfsh_addr  in  16  refresh address (I,R) for fetch T3/T4
- dout_in  in  8  write data
- din_out  out  8  read data; valid while `done`=1
- done  out  1  one-cycle pulse after the final T-state of a cycle
- A  out  16  address pins
- D_out  out  8  data pins, driven when `d_oe`=1
- d_oe  out  1  data-pin output enable
- D_in  in  8  data pins, input
- pin_oe  out  1  enable for A and the control strobes; 0 = tri-state
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  out  1 each  active-low strobes
- nWAIT  in  1  active-low wait, sampled synchronously
- nBUSRQ  in  1  active-low bus request
- nBUSACK  out  1  active-low bus acknowledge

## Operation
- States: IDLE, T1, T2, TW, T3, T4, BUSACK.
- Accept: `req_ready`=1 in IDLE and in the final T-state (T3 for types 1-4, T4 for fetch). On accept, latch `addr_in`, `req_type`, `dout_in`, then go to T1. A back-to-back request goes directly from the final T-state to T1.
- Reserved type: accepted and dropped. No state change, no `done`.
- Bus request: in IDLE or the final T-state, `nBUSRQ`=0 wins over `req_valid`, and `req_ready`=0 that cycle. Next state is BUSACK: `nBUSACK`=0, `pin_oe`=0, `d_oe`=0. Leave BUSACK to IDLE on the first edge that samples `nBUSRQ`=1.
- Strobe values per state; every unlisted strobe is 1:
  - T1: A=addr. Fetch: nM1=0, nMREQ=0, nRD=0. Mem rd: nMREQ=0, nRD=0. Mem wr: nMREQ=0.
  - T2/TW: T1 values, plus mem wr nWR=0, IO rd nIORQ=0 and nRD=0, IO wr nIORQ=0 and nWR=0.
  - T3, non-fetch: same as T2.
  - Fetch T3/T4: A=rfsh_addr, nMREQ=0, nRFSH=0, nM1=1, nRD=1.
- Write cycles: `d_oe`=1 and D_out=latched data from T1 through T3. `d_oe`=0 otherwise.
- Transitions:
  - T1→T2.
  - T2→TW if `nWAIT`=0 is sampled, or if the cycle is IO (forced single TW). Otherwise T2→T3.
  - TW→TW while `nWAIT`=0 is sampled, else TW→T3.
  - T3→T4 (fetch).
  - The final T-state goes to IDLE, to T1 (new request) or to BUSACK.
- Read capture into `din_out`:
  - Fetch: on the edge leaving T2/TW for T3.
  - Mem/IO read: on the edge leaving T3.
  - `din_out` holds its value until the next capture.
- `done`=1 for the single cycle following the final T-state, including when that cycle is T1 of the next request.

## Timing
- Reset values: state IDLE, A=0, all strobes 1, `nBUSACK`=1, `pin_oe`=1, `d_oe`=0, D_out=0, din_out=0, done=0.
- `req_ready`=1 once reset is released, unless `nBUSRQ`=0.
- Reset asserted mid-cycle aborts immediately (asynchronously) to the reset values. No `done` is produced for the aborted cycle.
- Latency, accept edge to `done` rising, with W waits:
  - Mem rd/wr: 3+W cycles.
  - Fetch: 4+W cycles.
  - IO: 4+W cycles; W counts extra waits beyond the forced TW.
- `nWAIT` is only sampled on edges leaving T2 or TW; it is ignored elsewhere.
- `nBUSRQ` is only sampled in IDLE, the final T-state and BUSACK; it never interrupts a cycle.

## Test plan
- Mem read, `addr_in`=16'h1234, D_in=8'h5A, nWAIT=1:
  - T1: A=1234, nMREQ=0, nRD=0.
  - 3 cycles after accept: done=1 and din_out=5A.
- Fetch, addr 16'h0000, rfsh_addr=16'h3F07, nWAIT low for 2 edges:
  - States T1, T2, TW, TW, T3, T4.
  - T3/T4: A=3F07, nRFSH=0, nM1=1.
  - din_out captured at TW→T3.
  - done 6 cycles after accept.
- IO write, addr 16'h00FE, dout_in=8'hA5:
  - nIORQ=0 and nWR=0 in T2/TW/T3 only.
  - d_oe=1 with D_out=A5 over T1-T3.
  - Exactly one forced TW; done after 4 cycles.
- Back-to-back:
  - Mem wr 16'hFFFF followed by mem rd 16'h0001 presented during T3: the next state is T1 with no IDLE cycle between.
  - done pulses during the new T1.
- nBUSRQ=0 during a mem read:
  - The cycle completes.
  - Then BUSACK: nBUSACK=0, pin_oe=0, req_ready=0.
  - After nBUSRQ=1: IDLE, nBUSACK=1.
- nreset pulsed low during TW of an IO read:
  - Immediately: all strobes 1, A=0, d_oe=0.
  - After release: IDLE, with no done pulse.
